line_repeat_1x2: RTL and testbench

Vertical 2x line repeater for the RGB888 video path. It is the inverse of the alternate-line decimator. The input keeps its full vs/hs timing, but de is asserted only on every other line. The block stores each active source line in a line buffer and replays it, at the same horizontal position, on the following line where de is absent. It sits directly downstream of a decimating stage or any half-vertical-rate source.

---
 rtl/video_pkg.sv | 28 ++
 rtl/line_repeat_1x2_if.sv | 38 +++
 rtl/line_buffer_1p.sv | 37 +++
 rtl/line_repeat_1x2.sv | 219 +++++++++++++++++++++
 tb/tb_line_repeat_1x2.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// ----------------------------------------------------------------------------
// video_pkg
// Shared definitions for the RGB888 video scaler path.
//   rep_state_t       : line repeater FSM state encoding
//   rgb888_t          : packed RGB888 pixel {r, g, b}
//   MODE_BYPASS_BIT   : image_mode bit selecting bypass (1) or repeat (0)
//   DEFAULT_MAX_WIDTH : default line buffer depth in pixels
// ----------------------------------------------------------------------------
package video_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SRC      = 2'd1,
        ST_REP_WAIT = 2'd2,
        ST_REP_LINE = 2'd3
    } rep_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    localparam int MODE_BYPASS_BIT   = 0;
    localparam int DEFAULT_MAX_WIDTH = 2048;
    localparam int PIX_W             = 24;

endpackage

// File: rtl/line_repeat_1x2_if.sv
// ----------------------------------------------------------------------------
// line_repeat_1x2_if
// Video bus of the 2x vertical line repeater.
//   vs_i/hs_i/de_i, rgb_*_i, image_mode_i : source video and mode control
//   vs_o/hs_o/de_o, rgb_*_o, overrun_o    : repeated video and overrun pulse
// Modports:
//   slave  : the repeater (consumes *_i, produces *_o)
//   master : the upstream driver / observer
// ----------------------------------------------------------------------------
interface line_repeat_1x2_if;

    logic       vs_i;
    logic       hs_i;
    logic       de_i;
    logic [7:0] rgb_r_i;
    logic [7:0] rgb_g_i;
    logic [7:0] rgb_b_i;
    logic [7:0] image_mode_i;

    logic       vs_o;
    logic       hs_o;
    logic       de_o;
    logic [7:0] rgb_r_o;
    logic [7:0] rgb_g_o;
    logic [7:0] rgb_b_o;
    logic       overrun_o;

    modport slave (
        input  vs_i, hs_i, de_i, rgb_r_i, rgb_g_i, rgb_b_i, image_mode_i,
        output vs_o, hs_o, de_o, rgb_r_o, rgb_g_o, rgb_b_o, overrun_o
    );

    modport master (
        output vs_i, hs_i, de_i, rgb_r_i, rgb_g_i, rgb_b_i, image_mode_i,
        input  vs_o, hs_o, de_o, rgb_r_o, rgb_g_o, rgb_b_o, overrun_o
    );

endinterface

// File: rtl/line_buffer_1p.sv
// ----------------------------------------------------------------------------
// line_buffer_1p
// Single-port synchronous line RAM with registered read (1-clock latency).
//   clock : clock
//   we    : write enable, writes wdata to addr
//   re    : read enable, rdata <= mem[addr] on the next edge
//   addr  : shared read/write address
//   wdata : write data
//   rdata : registered read data (holds when re is low)
// ----------------------------------------------------------------------------
module line_buffer_1p
    import video_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_MAX_WIDTH,
    parameter int AW     = $clog2(DEPTH),
    parameter int DATA_W = PIX_W
) (
    input  logic              clock,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/line_repeat_1x2.sv
// ----------------------------------------------------------------------------
// line_repeat_1x2
// Vertical 2x line repeater for RGB888 video. Every active source line is
// stored and replayed at the same horizontal position on the following line
// where de_i is absent. Syncs, de and pixels have a fixed 2-clock latency.
//   clock   : pixel clock
//   reset_n : asynchronous active-low reset
//   bus     : line_repeat_1x2_if.slave (syncs, pixels, image_mode, overrun)
// ----------------------------------------------------------------------------
module line_repeat_1x2
    import video_pkg::*;
#(
    parameter int MAX_WIDTH = DEFAULT_MAX_WIDTH,
    parameter int AW        = $clog2(MAX_WIDTH),
    parameter int HCW       = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    line_repeat_1x2_if.slave bus
);

    localparam logic [AW:0] MAX_CNT = (AW + 1)'(MAX_WIDTH);

    function automatic logic [HCW-1:0] sat_inc_h(input logic [HCW-1:0] v);
        return (v == {HCW{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [AW:0] sat_inc_w(input logic [AW:0] v);
        return (v >= MAX_CNT) ? MAX_CNT : v + 1'b1;
    endfunction

    rep_state_t      state, state_nx;
    logic            vs_d, hs_d, de_d;
    logic            vs_rise, hs_rise, de_rise, de_fall;
    logic            bypass_q;
    logic [HCW-1:0]  h_cnt_q, h_cnt;
    logic [HCW-1:0]  de_start;
    logic [AW:0]     de_len;
    logic [AW:0]     wr_addr, wr_base;
    logic            wr_fits, we, ovr_seen, ovr_hit;
    logic [AW:0]     rd_addr, rd_cur;
    logic            rd_busy, rep_cycle, rd_go, rd_last;
    logic [AW-1:0]   ram_addr;
    rgb888_t         pix_in, rgb_p0, rd_data, pix_o;
    logic            vs_p0, hs_p0, de_p0, ovr_p0, play_p0;
    logic            vs_o_q, hs_o_q, de_o_q, ovr_o_q;
    logic            unused_mode;

    assign unused_mode = ^bus.image_mode_i[7:1];
    assign pix_in      = {bus.rgb_r_i, bus.rgb_g_i, bus.rgb_b_i};

    assign vs_rise = bus.vs_i & ~vs_d;
    assign hs_rise = bus.hs_i & ~hs_d;
    assign de_rise = bus.de_i & ~de_d;
    assign de_fall = ~bus.de_i & de_d;

    // Position is 0 in the hs rise cycle itself, so de_start matches the
    // number of clocks from hs rise to the first pixel.
    assign h_cnt = hs_rise ? '0 : h_cnt_q;

    // Recording side: address restarts at the first pixel of every line.
    assign wr_base = de_rise ? '0 : wr_addr;
    assign wr_fits = (wr_base < MAX_CNT);
    assign we      = bus.de_i & wr_fits;
    assign ovr_hit = bus.de_i & ~wr_fits & (de_rise | ~ovr_seen);

    // Playback side. The hs rise cycle of REP_WAIT counts as part of the
    // replay line so a line starting at position 0 is not missed. Reads are
    // suppressed whenever de_i or vs rise is present, which keeps the single
    // RAM port free for the write and honours the abort priorities.
    assign rep_cycle = (state == ST_REP_LINE) | ((state == ST_REP_WAIT) & hs_rise);
    assign rd_go     = rep_cycle & ~bypass_q & ~vs_rise & ~bus.de_i & (de_len != '0)
                     & (rd_busy | (h_cnt == de_start));
    assign rd_cur    = rd_busy ? rd_addr : '0;
    assign rd_last   = rd_go & ((rd_cur + 1'b1) == de_len);

    assign ram_addr  = we ? wr_base[AW-1:0] : rd_cur[AW-1:0];

    line_buffer_1p #(
        .DEPTH  (MAX_WIDTH),
        .AW     (AW),
        .DATA_W (PIX_W)
    ) u_line_buffer (
        .clock (clock),
        .we    (we),
        .re    (rd_go),
        .addr  (ram_addr),
        .wdata (pix_in),
        .rdata (rd_data)
    );

    always_comb begin
        state_nx = state;
        if (vs_rise) begin
            state_nx = bus.image_mode_i[MODE_BYPASS_BIT] ? ST_IDLE : ST_SRC;
        end else if (de_rise && (state == ST_REP_WAIT || state == ST_REP_LINE)) begin
            state_nx = ST_SRC;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_nx = ST_IDLE;
                end
                ST_SRC: begin
                    if (de_fall && !bypass_q) begin
                        state_nx = ST_REP_WAIT;
                    end
                end
                ST_REP_WAIT: begin
                    if (hs_rise) begin
                        state_nx = rd_last ? ST_SRC : ST_REP_LINE;
                    end
                end
                ST_REP_LINE: begin
                    if (rd_last || de_len == '0) begin
                        state_nx = ST_SRC;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Control: edge history, mode latch, counters and line bookkeeping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vs_d     <= 1'b0;
            hs_d     <= 1'b0;
            de_d     <= 1'b0;
            bypass_q <= 1'b0;
            h_cnt_q  <= '0;
            de_start <= '0;
            de_len   <= '0;
            wr_addr  <= '0;
            ovr_seen <= 1'b0;
            rd_addr  <= '0;
            rd_busy  <= 1'b0;
        end else begin
            vs_d    <= bus.vs_i;
            hs_d    <= bus.hs_i;
            de_d    <= bus.de_i;
            h_cnt_q <= sat_inc_h(h_cnt);
            if (vs_rise) begin
                bypass_q <= bus.image_mode_i[MODE_BYPASS_BIT];
            end
            if (de_rise) begin
                de_start <= h_cnt;
            end
            if (de_fall) begin
                de_len <= wr_addr;
            end
            if (bus.de_i) begin
                wr_addr  <= sat_inc_w(wr_base);
                ovr_seen <= (ovr_seen & ~de_rise) | ~wr_fits;
            end
            rd_busy <= rd_go & ~rd_last;
            if (rd_go) begin
                rd_addr <= rd_cur + 1'b1;
            end
        end
    end

    // Stage p0: first delay of syncs/de/pixels; buffer read data returns.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vs_p0   <= 1'b0;
            hs_p0   <= 1'b0;
            de_p0   <= 1'b0;
            ovr_p0  <= 1'b0;
            play_p0 <= 1'b0;
        end else begin
            vs_p0   <= bus.vs_i;
            hs_p0   <= bus.hs_i;
            de_p0   <= bus.de_i;
            ovr_p0  <= ovr_hit;
            play_p0 <= rd_go;
        end
    end

    always_ff @(posedge clock) begin
        rgb_p0 <= pix_in;
    end

    // Stage p1: output register, replayed pixels take priority over the
    // delayed input.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vs_o_q  <= 1'b0;
            hs_o_q  <= 1'b0;
            de_o_q  <= 1'b0;
            ovr_o_q <= 1'b0;
            pix_o   <= '0;
        end else begin
            vs_o_q  <= vs_p0;
            hs_o_q  <= hs_p0;
            de_o_q  <= play_p0 | de_p0;
            ovr_o_q <= ovr_p0;
            pix_o   <= play_p0 ? rd_data : rgb_p0;
        end
    end

    assign bus.vs_o      = vs_o_q;
    assign bus.hs_o      = hs_o_q;
    assign bus.de_o      = de_o_q;
    assign bus.overrun_o = ovr_o_q;
    assign bus.rgb_r_o   = pix_o.r;
    assign bus.rgb_g_o   = pix_o.g;
    assign bus.rgb_b_o   = pix_o.b;

endmodule

// File: tb/tb_line_repeat_1x2.sv
// ----------------------------------------------------------------------------
// tb_line_repeat_1x2
// Directed bench for line_repeat_1x2 with a 16-pixel line buffer. Each line
// is driven cycle by cycle; outputs are compared on the falling edge against
// the expected 2-clock-delayed pattern of that line.
// ----------------------------------------------------------------------------
module tb_line_repeat_1x2;

    localparam int MAXW = 16;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    line_repeat_1x2_if vif ();

    line_repeat_1x2 #(
        .MAX_WIDTH (MAXW),
        .AW        (4),
        .HCW       (16)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (vif)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of source video at horizontal position h: hs at 0-1, vs for
    // 4 clocks from vs_h (negative = none), npix pixels from position 5.
    task automatic drive_cycle(input int h, input int vs_h, input bit de_on,
                               input int npix, input logic [7:0] base);
        logic       de;
        logic [7:0] v;
        @(posedge clock);
        #1;
        de = de_on && (h >= 5) && (h < 5 + npix);
        v  = base + 8'(h - 5);
        vif.hs_i    = (h < 2);
        vif.vs_i    = (vs_h >= 0) && (h >= vs_h) && (h < vs_h + 4);
        vif.de_i    = de;
        vif.rgb_r_i = de ? v : 8'h00;
        vif.rgb_g_i = de ? v + 8'h40 : 8'h00;
        vif.rgb_b_i = de ? v + 8'h80 : 8'h00;
    endtask

    // Drive a whole line and check every output cycle. Expected de_o covers
    // positions 7..7+exp_n-1 with pixel values counting up from exp_base.
    task automatic run_line(input string tag, input int len, input int vs_h,
                            input bit de_on, input int npix, input logic [7:0] base,
                            input int exp_n, input logic [7:0] exp_base,
                            input int exp_ovr_h);
        logic        e_de, e_hs, e_vs, e_ovr;
        logic [7:0]  e_v;
        logic [23:0] e_pix;
        for (int h = 0; h < len; h++) begin
            drive_cycle(h, vs_h, de_on, npix, base);
            @(negedge clock);
            e_de  = (h >= 7) && (h < 7 + exp_n);
            e_v   = exp_base + 8'(h - 7);
            e_pix = e_de ? {e_v, e_v + 8'h40, e_v + 8'h80} : 24'h0;
            e_hs  = (h == 2) || (h == 3);
            e_vs  = (vs_h >= 0) && (h >= vs_h + 2) && (h < vs_h + 6);
            e_ovr = (h == exp_ovr_h);
            check($sformatf("%s h%0d de_o", tag, h), 24'(vif.de_o), 24'(e_de));
            check($sformatf("%s h%0d rgb_o", tag, h),
                  {vif.rgb_r_o, vif.rgb_g_o, vif.rgb_b_o}, e_pix);
            check($sformatf("%s h%0d hs_o", tag, h), 24'(vif.hs_o), 24'(e_hs));
            check($sformatf("%s h%0d vs_o", tag, h), 24'(vif.vs_o), 24'(e_vs));
            check($sformatf("%s h%0d overrun_o", tag, h), 24'(vif.overrun_o), 24'(e_ovr));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " vs_o"}, 24'(vif.vs_o), 24'h0);
        check({tag, " hs_o"}, 24'(vif.hs_o), 24'h0);
        check({tag, " de_o"}, 24'(vif.de_o), 24'h0);
        check({tag, " overrun_o"}, 24'(vif.overrun_o), 24'h0);
        check({tag, " rgb_o"}, {vif.rgb_r_o, vif.rgb_g_o, vif.rgb_b_o}, 24'h0);
    endtask

    task automatic inputs_idle();
        vif.vs_i    = 1'b0;
        vif.hs_i    = 1'b0;
        vif.de_i    = 1'b0;
        vif.rgb_r_i = 8'h00;
        vif.rgb_g_i = 8'h00;
        vif.rgb_b_i = 8'h00;
    endtask

    initial begin
        // Reset with busy inputs: outputs must stay at 0.
        reset_n          = 1'b0;
        vif.image_mode_i = 8'h00;
        vif.vs_i         = 1'b1;
        vif.hs_i         = 1'b1;
        vif.de_i         = 1'b1;
        vif.rgb_r_i      = 8'hFF;
        vif.rgb_g_i      = 8'hFF;
        vif.rgb_b_i      = 8'hFF;
        repeat (4) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        inputs_idle();
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        // Decimated frame, repeat mode.
        vif.image_mode_i = 8'h00;
        run_line("rep_l0", 20, 0,  1, 8, 8'h10, 8, 8'h10, -1);
        run_line("rep_l1", 20, -1, 0, 0, 8'h00, 8, 8'h10, -1);
        run_line("rep_l2", 20, -1, 1, 8, 8'h20, 8, 8'h20, -1);
        run_line("rep_l3", 20, -1, 0, 0, 8'h00, 8, 8'h20, -1);

        // Bypass frame: odd lines stay blank.
        vif.image_mode_i = 8'h01;
        run_line("byp_l0", 20, 0,  1, 8, 8'h40, 8, 8'h40, -1);
        run_line("byp_l1", 20, -1, 0, 0, 8'h00, 0, 8'h00, -1);
        run_line("byp_l2", 20, -1, 1, 8, 8'h48, 8, 8'h48, -1);
        run_line("byp_l3", 20, -1, 0, 0, 8'h00, 0, 8'h00, -1);

        // Undecimated input: every line is a source line, never a replay.
        vif.image_mode_i = 8'h00;
        run_line("und_l0", 20, 0,  1, 8, 8'h50, 8, 8'h50, -1);
        run_line("und_l1", 20, -1, 1, 8, 8'h60, 8, 8'h60, -1);
        run_line("und_l2", 20, -1, 1, 8, 8'h70, 8, 8'h70, -1);
        run_line("und_l3", 20, -1, 0, 0, 8'h00, 8, 8'h70, -1);

        // Overrun: 20-pixel source into a 16-pixel buffer.
        run_line("ovr_l0", 32, 0,  1, 20, 8'h80, 20, 8'h80, 23);
        run_line("ovr_l1", 32, -1, 0, 0,  8'h00, 16, 8'h80, -1);

        // vs rise at position 8 of a replay line aborts after 3 pixels.
        run_line("vsab_l0", 20, 0,  1, 8, 8'hA0, 8, 8'hA0, -1);
        run_line("vsab_l1", 20, 8,  0, 0, 8'h00, 3, 8'hA0, -1);
        run_line("vsab_l2", 20, -1, 1, 8, 8'hB0, 8, 8'hB0, -1);
        run_line("vsab_l3", 20, -1, 0, 0, 8'h00, 8, 8'hB0, -1);

        // Reset in the middle of a replay line.
        run_line("rst_l0", 20, 0, 1, 8, 8'hC0, 8, 8'hC0, -1);
        for (int h = 0; h < 9; h++) begin
            drive_cycle(h, -1, 1'b0, 0, 8'h00);
        end
        @(negedge clock);
        check("rst_pre de_o", 24'(vif.de_o), 24'h1);
        check("rst_pre rgb_o", {vif.rgb_r_o, vif.rgb_g_o, vif.rgb_b_o}, 24'hC1_01_41);
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        inputs_idle();
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        run_line("rst_src",   20, -1, 1, 8, 8'hD0, 8, 8'hD0, -1);
        run_line("rst_norep", 20, -1, 0, 0, 8'h00, 0, 8'h00, -1);
        run_line("rst_frame", 20, 0,  1, 8, 8'hE0, 8, 8'hE0, -1);
        run_line("rst_rep",   20, -1, 0, 0, 8'h00, 8, 8'hE0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
